// File: rtl/anubis_round_key_buffer.sv
// rtl/anubis_round_key_buffer.sv - round-key store replaying keys to the sigma stage
//
// Holds NUM_KEYS round keys written by the key schedule in index order, then
// streams them one per round to the key-addition stage, ascending for
// encryption and descending for decryption. Keys are replayed bit-exact.
//
// Ports:
//   clk, reset              rising-edge clock, synchronous active-high reset
//   clear                   pulse: drop all keys and return to EMPTY
//   wr_valid/wr_ready/wr_key   key-schedule write handshake
//   loaded                  all NUM_KEYS keys present
//   rd_start, rd_dir        begin a stream (rd_dir: 0 ascending, 1 descending)
//   rd_advance              current key consumed, present the next one
//   skey, skey_valid, skey_idx, skey_last   registered key output
//   done                    pulse after the final key is advanced past

module anubis_round_key_buffer #(
    parameter int NUM_KEYS = 13,
    parameter int KW       = 128,
    localparam int IW      = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [KW-1:0] wr_key,
    output logic          loaded,
    input  logic          rd_start,
    input  logic          rd_dir,
    input  logic          rd_advance,
    output logic [KW-1:0] skey,
    output logic          skey_valid,
    output logic [IW-1:0] skey_idx,
    output logic          skey_last,
    output logic          done
);

    typedef enum logic [1:0] {
        S_EMPTY,
        S_LOADING,
        S_LOADED,
        S_STREAM
    } state_t;

    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_KEYS - 1);

    state_t        state;
    logic [KW-1:0] storage [NUM_KEYS];
    logic [IW-1:0] wr_ptr;
    logic          dir;
    logic [IW-1:0] next_idx;
    logic          wr_fire;

    // wr_ready is only high in EMPTY/LOADING, so it alone qualifies the state.
    assign wr_fire = wr_valid && wr_ready && !reset && !clear;

    // Only evaluated while skey_last is low, so it never steps past either end.
    always_comb begin
        next_idx = dir ? (skey_idx - 1'b1) : (skey_idx + 1'b1);
    end

    // Key storage is deliberately not reset; the FSM refuses to stream until
    // a full reload has happened.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            storage[wr_ptr] <= wr_key;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_EMPTY;
            wr_ptr     <= '0;
            wr_ready   <= 1'b1;
            loaded     <= 1'b0;
            skey       <= '0;
            skey_valid <= 1'b0;
            skey_idx   <= '0;
            skey_last  <= 1'b0;
            done       <= 1'b0;
            dir        <= 1'b0;
        end else if (clear) begin
            // skey keeps its last value; only its valid flag drops.
            state      <= S_EMPTY;
            wr_ptr     <= '0;
            wr_ready   <= 1'b1;
            loaded     <= 1'b0;
            skey_valid <= 1'b0;
            skey_last  <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_EMPTY, S_LOADING: begin
                    if (wr_valid && wr_ready) begin
                        wr_ptr <= wr_ptr + 1'b1;
                        if (wr_ptr == LAST_IDX) begin
                            state    <= S_LOADED;
                            wr_ready <= 1'b0;
                            loaded   <= 1'b1;
                        end else begin
                            state <= S_LOADING;
                        end
                    end
                end
                S_LOADED: begin
                    if (rd_start) begin
                        state      <= S_STREAM;
                        dir        <= rd_dir;
                        skey       <= storage[rd_dir ? LAST_IDX : '0];
                        skey_idx   <= rd_dir ? LAST_IDX : '0;
                        skey_valid <= 1'b1;
                        skey_last  <= (NUM_KEYS == 1);
                    end
                end
                S_STREAM: begin
                    if (rd_advance) begin
                        if (skey_last) begin
                            state      <= S_LOADED;
                            skey_valid <= 1'b0;
                            skey_last  <= 1'b0;
                            done       <= 1'b1;
                        end else begin
                            skey_idx  <= next_idx;
                            skey      <= storage[next_idx];
                            skey_last <= dir ? (next_idx == '0) : (next_idx == LAST_IDX);
                        end
                    end
                end
                default: state <= S_EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_anubis_round_key_buffer.sv
// tb/tb_anubis_round_key_buffer.sv - self-checking bench for anubis_round_key_buffer

module tb_anubis_round_key_buffer;

    localparam int N  = 13;
    localparam int KW = 128;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          clear = 1'b0;
    logic          wr_valid = 1'b0;
    logic          wr_ready;
    logic [KW-1:0] wr_key = '0;
    logic          loaded;
    logic          rd_start = 1'b0;
    logic          rd_dir = 1'b0;
    logic          rd_advance = 1'b0;
    logic [KW-1:0] skey;
    logic          skey_valid;
    logic [3:0]    skey_idx;
    logic          skey_last;
    logic          done;

    anubis_round_key_buffer #(.NUM_KEYS(N), .KW(KW)) dut (
        .clk(clk), .reset(reset), .clear(clear),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_key(wr_key),
        .loaded(loaded), .rd_start(rd_start), .rd_dir(rd_dir),
        .rd_advance(rd_advance), .skey(skey), .skey_valid(skey_valid),
        .skey_idx(skey_idx), .skey_last(skey_last), .done(done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [KW-1:0] ld_keys   [N];
    logic [KW-1:0] model_mem [N];
    int            start_pulse_at = -1;

    typedef struct {
        logic       reload;
        int         pattern;
        logic       dir;
        int         period;     // 0: random advance pattern
        logic [3:0] exp_first;
        logic [3:0] exp_final;
    } vec_t;

    vec_t vecs [5];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [KW-1:0] act, input logic [KW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic make_keys(input int pattern);
        for (int i = 0; i < N; i++) begin
            logic [7:0] b;
            b = 8'(i);
            case (pattern)
                0:       ld_keys[i] = {16{b}};
                1:       ld_keys[i] = ~{16{b}};
                default: ld_keys[i] = {$urandom, $urandom, $urandom, $urandom};
            endcase
        end
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_wr_ready"}, KW'(wr_ready), 1);
        chk({tag, "_loaded"}, KW'(loaded), 0);
        chk({tag, "_skey"}, skey, 0);
        chk({tag, "_skey_valid"}, KW'(skey_valid), 0);
        chk({tag, "_skey_idx"}, KW'(skey_idx), 0);
        chk({tag, "_skey_last"}, KW'(skey_last), 0);
        chk({tag, "_done"}, KW'(done), 0);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic do_load();
        for (int i = 0; i < N; i++) begin
            if (i == start_pulse_at) begin
                wr_valid = 1'b0;
                rd_start = 1'b1;
                rd_dir   = 1'b0;
                tick();
                rd_start = 1'b0;
                chk("start_in_loading_valid", KW'(skey_valid), 0);
                chk("start_in_loading_loaded", KW'(loaded), 0);
            end
            wr_valid = 1'b1;
            wr_key   = ld_keys[i];
            chk("load_wr_ready", KW'(wr_ready), 1);
            if (i == N - 1) chk("loaded_before_last", KW'(loaded), 0);
            tick();
        end
        wr_valid = 1'b0;
        chk("loaded_after_load", KW'(loaded), 1);
        chk("wr_ready_after_load", KW'(wr_ready), 0);
        model_mem = ld_keys;
    endtask

    task automatic do_stream(input logic d, input int period,
                             input logic [3:0] exp_first, input logic [3:0] exp_final);
        int k;
        int hold;
        int cycles;
        logic adv;
        int e;
        rd_start = 1'b1;
        rd_dir   = d;
        tick();
        rd_start = 1'b0;
        rd_dir   = ~d;          // direction must be held from the start
        chk("first_idx", KW'(skey_idx), KW'(exp_first));
        k = 0;
        hold = 0;
        cycles = 0;
        while (k < N && cycles < 2000) begin
            e = d ? (N - 1 - k) : k;
            chk("stream_valid", KW'(skey_valid), 1);
            chk("stream_idx", KW'(skey_idx), KW'(e));
            chk("stream_key", skey, model_mem[e]);
            chk("stream_last", KW'(skey_last), KW'(k == N - 1));
            chk("stream_done", KW'(done), 0);
            if (k == N - 1) chk("final_idx", KW'(skey_idx), KW'(exp_final));
            if (period > 0) begin
                adv = (hold == period - 1);
            end else begin
                adv = 1'($urandom % 2);
                rd_start = 1'($urandom % 2);    // ignored while streaming
            end
            rd_advance = adv;
            tick();
            if (adv) begin
                k++;
                hold = 0;
            end else begin
                hold++;
            end
            cycles++;
        end
        rd_advance = 1'b0;
        rd_start   = 1'b0;
        chk("stream_bound", KW'(k), KW'(N));
        chk("done_pulse", KW'(done), 1);
        chk("valid_after_done", KW'(skey_valid), 0);
        chk("loaded_after_done", KW'(loaded), 1);
        tick();
        chk("done_one_cycle", KW'(done), 0);
    endtask

    initial begin
        vecs[0] = '{1'b1, 0, 1'b0, 1, 4'd0,  4'd12};
        vecs[1] = '{1'b0, 0, 1'b1, 3, 4'd12, 4'd0};
        vecs[2] = '{1'b1, 2, 1'b0, 0, 4'd0,  4'd12};
        vecs[3] = '{1'b0, 2, 1'b1, 0, 4'd12, 4'd0};
        vecs[4] = '{1'b1, 1, 1'b0, 2, 4'd0,  4'd12};

        tick();
        tick();
        reset = 1'b0;
        check_reset_values("reset");

        for (int v = 0; v < 5; v++) begin
            if (vecs[v].reload) begin
                do_clear();
                make_keys(vecs[v].pattern);
                do_load();
            end
            do_stream(vecs[v].dir, vecs[v].period, vecs[v].exp_first, vecs[v].exp_final);
        end

        // rd_start offered while loading is ignored; loading then completes
        do_clear();
        make_keys(0);
        start_pulse_at = 5;
        do_load();
        start_pulse_at = -1;
        do_stream(1'b0, 1, 4'd0, 4'd12);

        // 14th write offered after load must not change storage
        wr_valid = 1'b1;
        wr_key   = {4{32'hDEADBEEF}};
        tick();
        tick();
        wr_valid = 1'b0;
        chk("extra_wr_ready", KW'(wr_ready), 0);
        chk("extra_loaded", KW'(loaded), 1);
        do_stream(1'b1, 1, 4'd12, 4'd0);

        // clear at idx 6 of an ascending stream
        rd_start = 1'b1;
        rd_dir   = 1'b0;
        tick();
        rd_start = 1'b0;
        rd_advance = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        rd_advance = 1'b0;
        chk("pre_clear_idx", KW'(skey_idx), 6);
        do_clear();
        chk("clear_valid", KW'(skey_valid), 0);
        chk("clear_loaded", KW'(loaded), 0);
        chk("clear_wr_ready", KW'(wr_ready), 1);
        chk("clear_last", KW'(skey_last), 0);
        chk("clear_skey_held", skey, model_mem[6]);
        make_keys(1);
        do_load();
        do_stream(1'b0, 1, 4'd0, 4'd12);

        // clear and rd_start together in LOADED
        clear = 1'b1;
        rd_start = 1'b1;
        tick();
        clear = 1'b0;
        tick();
        rd_start = 1'b0;
        chk("clr_start_valid", KW'(skey_valid), 0);
        chk("clr_start_loaded", KW'(loaded), 0);
        chk("clr_start_wr_ready", KW'(wr_ready), 1);

        // reset mid-stream
        make_keys(2);
        do_load();
        rd_start = 1'b1;
        rd_dir   = 1'b1;
        tick();
        rd_start = 1'b0;
        rd_advance = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        rd_advance = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_reset_values("midreset");
        rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
        chk("start_after_reset_valid", KW'(skey_valid), 0);
        do_clear();
        do_load();
        do_stream(1'b1, 2, 4'd12, 4'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
